// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store memory controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

   localparam int XLEN = 32;

   // RV32I funct3 codes. Load and store codes overlap, so they need two enums.
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_f3_e;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_f3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RSP  = 2'd3
   } state_t;

   // True when funct3 names a supported access of the given direction.
   function automatic logic is_legal(input logic wr, input logic [2:0] funct3);
      logic ok;
      ok = 1'b0;
      if (wr) begin
         case (funct3)
            SB, SH, SW: ok = 1'b1;
            default:    ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            LB, LH, LW, LBU, LHU: ok = 1'b1;
            default:              ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Size is encoded in funct3[1:0] for both loads and stores.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = |addr_lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Data path helper: load extract/extend and sub-word store merge.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports: rdata/funct3 -> load_data (sign/zero extended from byte 0 / bytes 1:0);
//        old_word/wdata/funct3 -> store_data (store bytes merged into old_word).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [XLEN-1:0] old_word,
   input  logic [XLEN-1:0] wdata,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] store_data
);

   always_comb begin
      load_data = rdata;
      case (funct3)
         LB:      load_data = {{24{rdata[7]}}, rdata[7:0]};
         LBU:     load_data = {24'd0, rdata[7:0]};
         LH:      load_data = {{16{rdata[15]}}, rdata[15:0]};
         LHU:     load_data = {16'd0, rdata[15:0]};
         default: load_data = rdata;
      endcase
   end

   // The memory always writes a whole word, so sub-word stores keep the
   // upper bytes of the word that was just read back.
   always_comb begin
      store_data = wdata;
      case (funct3)
         SB:      store_data = {old_word[31:8], wdata[7:0]};
         SH:      store_data = {old_word[31:16], wdata[15:0]};
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a byte-addressed word-wide memory (sub-word stores use read-modify-write).
// Latency from accept cycle N: load/SW response in N+2, SB/SH in N+3, error in N+1.
// Backpressure: one request in flight, req_ready low outside IDLE; no response backpressure.
//
// Ports: clk/reset (sync, active high); req_* request handshake and fields;
//        rsp_valid/rsp_rdata/rsp_err one-cycle response; mem_* drive the memory,
//        mem_rdata is the memory's combinational read data. All outputs are flops.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEMSIZE     = 'h400,
   parameter int unsigned DWIDTH      = 32,
   parameter bit          ALIGN_CHECK = 1'b1,
   localparam int unsigned WIDTH      = $clog2(MEMSIZE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [2:0]        req_funct3,
   input  logic [WIDTH-1:0]  req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [WIDTH-1:0]  mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [2:0]        f3_q, f3_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;

   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wen_q, mem_wen_d;
   logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic [DWIDTH-1:0] load_data;
   logic [DWIDTH-1:0] store_data;
   logic              req_bad;

   // mem_rdata is valid during RD; the merge result is registered straight
   // into mem_wdata so the WR cycle needs no extra capture register.
   lsu_align u_align (
      .rdata      (mem_rdata),
      .old_word   (mem_rdata),
      .wdata      (wdata_q),
      .funct3     (f3_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      f3_d        = f3_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      req_bad     = 1'b0;

      case (state_q)
         IDLE: begin
            // req_ready_q rather than the state alone: ready stays low for the
            // first cycle after reset releases.
            if (req_valid && req_ready_q) begin
               wr_d    = req_wr;
               f3_d    = req_funct3;
               wdata_d = req_wdata;
               req_bad = !is_legal(req_wr, req_funct3) ||
                         (ALIGN_CHECK && is_misaligned(req_funct3, req_addr[1:0]));
               if (req_bad) begin
                  state_d     = RSP;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  mem_addr_d = req_addr;
                  if (req_wr && (req_funct3 == SW)) begin
                     state_d     = WR;
                     mem_wdata_d = req_wdata;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            if (wr_q) begin
               state_d     = WR;
               mem_wdata_d = store_data;
            end else begin
               state_d     = RSP;
               rsp_rdata_d = load_data;
            end
         end
         WR: begin
            state_d     = RSP;
            rsp_rdata_d = '0;
         end
         RSP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
      mem_en_d    = (state_d == RD) || (state_d == WR);
      mem_wen_d   = (state_d == WR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         f3_q        <= 3'd0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         f3_q        <= f3_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_en_q    <= mem_en_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_en    = mem_en_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
